// File: rtl/traffic_light_sequencer.sv
// Highway/farm-road traffic light controller that sequences a 4-bit interval timer.
// Night flashing mode is compiled in when NIGHT_FLASH_EN is defined.
module traffic_light_sequencer #(
    parameter logic [3:0] T_BASE_DEF = 4'd6,
    parameter logic [3:0] T_EXT_DEF  = 4'd3,
    parameter logic [3:0] T_YEL_DEF  = 4'd2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       sensor,
    input  logic       walk_btn,
`ifdef NIGHT_FLASH_EN
    input  logic       night,
`endif
    input  logic       expired,
    input  logic       prog_sync,
    input  logic [1:0] time_sel,
    input  logic [3:0] time_value,
    output logic [3:0] interval,
    output logic       start_timer,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk_lamp
);

    localparam int unsigned TW = 4;
    localparam int unsigned LW = 7;

    // Lamp bundles packed as {main RYG, side RYG, walk}
    localparam logic [LW-1:0] L_MAIN_GRN = 7'b001_100_0;
    localparam logic [LW-1:0] L_MAIN_YEL = 7'b010_100_0;
    localparam logic [LW-1:0] L_WALK     = 7'b100_100_1;
    localparam logic [LW-1:0] L_SIDE_GRN = 7'b100_001_0;
    localparam logic [LW-1:0] L_SIDE_YEL = 7'b100_010_0;
    localparam logic [LW-1:0] L_ALL_RED  = 7'b100_100_0;
`ifdef NIGHT_FLASH_EN
    localparam logic [LW-1:0] L_FLASH_ON  = 7'b010_100_0;
    localparam logic [LW-1:0] L_FLASH_OFF = 7'b000_000_0;
`endif

`ifdef NIGHT_FLASH_EN
    typedef enum logic [2:0] {
        MAIN_GRN, MAIN_GRN2, MAIN_YEL, WALK, SIDE_GRN, SIDE_YEL, FLASH
    } state_t;
`else
    typedef enum logic [2:0] {
        MAIN_GRN, MAIN_GRN2, MAIN_YEL, WALK, SIDE_GRN, SIDE_YEL
    } state_t;
`endif

    state_t         state;
    logic [TW-1:0]  t_base;
    logic [TW-1:0]  t_ext;
    logic [TW-1:0]  t_yel;
    logic           walk_req;
    logic           expired_q;
    logic           boot_pend;
`ifdef NIGHT_FLASH_EN
    logic           flash_lit;
`endif

    logic           exp_evt;
    logic           prog_wr;
    logic [TW-1:0]  wr_val;

    // Rising edge of expiry, masked while the timer is being (re)started
    assign exp_evt = expired & ~expired_q & ~start_timer;
    assign prog_wr = prog_sync & (time_sel != 2'b11);
    assign wr_val  = (time_value == '0) ? TW'(1) : time_value;

    function automatic state_t seq_next(input state_t s, input logic wreq);
        case (s)
            MAIN_GRN:  seq_next = MAIN_GRN2;
            MAIN_GRN2: seq_next = MAIN_YEL;
            MAIN_YEL:  seq_next = wreq ? WALK : SIDE_GRN;
            WALK:      seq_next = SIDE_GRN;
            SIDE_GRN:  seq_next = SIDE_YEL;
            default:   seq_next = MAIN_GRN;
        endcase
    endfunction

    function automatic logic [TW-1:0] seq_interval(input state_t s, input logic sens,
                                                   input logic [TW-1:0] tb,
                                                   input logic [TW-1:0] te,
                                                   input logic [TW-1:0] ty);
        case (s)
            MAIN_GRN:            seq_interval = tb;
            MAIN_GRN2, SIDE_GRN: seq_interval = sens ? te : tb;
            MAIN_YEL, SIDE_YEL:  seq_interval = ty;
            WALK:                seq_interval = te;
            default:             seq_interval = TW'(1);
        endcase
    endfunction

    function automatic logic [LW-1:0] seq_lamps(input state_t s);
        case (s)
            MAIN_GRN, MAIN_GRN2: seq_lamps = L_MAIN_GRN;
            MAIN_YEL:            seq_lamps = L_MAIN_YEL;
            WALK:                seq_lamps = L_WALK;
            SIDE_GRN:            seq_lamps = L_SIDE_GRN;
            SIDE_YEL:            seq_lamps = L_SIDE_YEL;
            default:             seq_lamps = L_ALL_RED;
        endcase
    endfunction

    // State, interval registers and all outputs
    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= MAIN_GRN;
            t_base      <= T_BASE_DEF;
            t_ext       <= T_EXT_DEF;
            t_yel       <= T_YEL_DEF;
            walk_req    <= 1'b0;
            expired_q   <= 1'b0;
            boot_pend   <= 1'b1;
            interval    <= T_BASE_DEF;
            start_timer <= 1'b0;
            {main_lights, side_lights, walk_lamp} <= L_MAIN_GRN;
`ifdef NIGHT_FLASH_EN
            flash_lit   <= 1'b0;
`endif
        end else begin
            expired_q   <= expired;
            start_timer <= 1'b0;
            if (walk_btn && (state != WALK)) begin
                walk_req <= 1'b1;
            end

            if (prog_wr) begin
                // A valid write restarts the cycle from MAIN_GRN with the new values
                case (time_sel)
                    2'b00:   t_base <= wr_val;
                    2'b01:   t_ext  <= wr_val;
                    default: t_yel  <= wr_val;
                endcase
                state       <= MAIN_GRN;
                interval    <= (time_sel == 2'b00) ? wr_val : t_base;
                start_timer <= 1'b1;
                boot_pend   <= 1'b0;
                {main_lights, side_lights, walk_lamp} <= L_MAIN_GRN;
            end else if (boot_pend) begin
                boot_pend   <= 1'b0;
                interval    <= t_base;
                start_timer <= 1'b1;
            end else if (exp_evt) begin
                start_timer <= 1'b1;
`ifdef NIGHT_FLASH_EN
                if (night) begin
                    state    <= FLASH;
                    interval <= TW'(1);
                    if ((state == FLASH) && flash_lit) begin
                        flash_lit <= 1'b0;
                        {main_lights, side_lights, walk_lamp} <= L_FLASH_OFF;
                    end else begin
                        flash_lit <= 1'b1;
                        {main_lights, side_lights, walk_lamp} <= L_FLASH_ON;
                    end
                end else
`endif
                begin
                    state    <= seq_next(state, walk_req);
                    interval <= seq_interval(seq_next(state, walk_req), sensor,
                                             t_base, t_ext, t_yel);
                    {main_lights, side_lights, walk_lamp} <= seq_lamps(seq_next(state, walk_req));
                    if (seq_next(state, walk_req) == WALK) begin
                        walk_req <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer: lamp/interval sequence, walk, programming, expiry edge cases.
module tb_traffic_light_sequencer;

    logic       clk = 1'b0;
    logic       Reset;
    logic       sensor;
    logic       walk_btn;
`ifdef NIGHT_FLASH_EN
    logic       night;
`endif
    logic       expired;
    logic       prog_sync;
    logic [1:0] time_sel;
    logic [3:0] time_value;
    logic [3:0] interval;
    logic       start_timer;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk_lamp;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [6:0] MG  = 7'b001_100_0;
    localparam logic [6:0] MY  = 7'b010_100_0;
    localparam logic [6:0] WK  = 7'b100_100_1;
    localparam logic [6:0] SG  = 7'b100_001_0;
    localparam logic [6:0] SY  = 7'b100_010_0;

    traffic_light_sequencer dut (
        .clk         (clk),
        .Reset       (Reset),
        .sensor      (sensor),
        .walk_btn    (walk_btn),
`ifdef NIGHT_FLASH_EN
        .night       (night),
`endif
        .expired     (expired),
        .prog_sync   (prog_sync),
        .time_sel    (time_sel),
        .time_value  (time_value),
        .interval    (interval),
        .start_timer (start_timer),
        .main_lights (main_lights),
        .side_lights (side_lights),
        .walk_lamp   (walk_lamp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] e_int, input logic e_st,
                       input logic [6:0] e_lamps);
        logic [6:0] lamps;
        lamps = {main_lights, side_lights, walk_lamp};
        n_tests++;
        assert (interval === e_int) else begin
            n_fail++;
            $error("FAIL %s interval: observed %0d expected %0d", tag, interval, e_int);
        end
        n_tests++;
        assert (start_timer === e_st) else begin
            n_fail++;
            $error("FAIL %s start_timer: observed %0b expected %0b", tag, start_timer, e_st);
        end
        n_tests++;
        assert (lamps === e_lamps) else begin
            n_fail++;
            $error("FAIL %s lamps: observed %b expected %b", tag, lamps, e_lamps);
        end
        n_tests++;
        assert (main_lights == 3'b100 || side_lights == 3'b100) else begin
            n_fail++;
            $error("FAIL %s both_non_red: observed %b/%b expected one red", tag,
                   main_lights, side_lights);
        end
    endtask

    // One expiry pulse, check the entered phase, then let the start pulse clear
    task automatic fire(input string tag, input logic [3:0] e_int, input logic [6:0] e_lamps);
        expired = 1'b1;
        tick();
        expired = 1'b0;
        chk(tag, e_int, 1'b1, e_lamps);
        tick();
        tick();
    endtask

    initial begin
        Reset = 1'b1; sensor = 1'b0; walk_btn = 1'b0; expired = 1'b0;
        prog_sync = 1'b0; time_sel = 2'b00; time_value = 4'd0;
`ifdef NIGHT_FLASH_EN
        night = 1'b0;
`endif
        tick(); tick(); tick();
        chk("reset", 4'd6, 1'b0, MG);

        Reset = 1'b0;
        tick();
        chk("boot_pulse", 4'd6, 1'b1, MG);
        tick();
        chk("boot_idle", 4'd6, 1'b0, MG);

        // Base cycle, no sensor
        fire("s0_grn2", 4'd6, MG);
        fire("s0_myel", 4'd2, MY);
        fire("s0_sgrn", 4'd6, SG);
        fire("s0_syel", 4'd2, SY);
        fire("s0_mgrn", 4'd6, MG);

        // Sensor extends both green phases
        sensor = 1'b1;
        fire("s1_grn2", 4'd3, MG);
        fire("s1_myel", 4'd2, MY);
        fire("s1_sgrn", 4'd3, SG);
        fire("s1_syel", 4'd2, SY);
        fire("s1_mgrn", 4'd6, MG);
        sensor = 1'b0;

        // Walk request latched in MAIN_GRN, served after MAIN_YEL
        walk_btn = 1'b1;
        tick();
        walk_btn = 1'b0;
        chk("walk_press", 4'd6, 1'b0, MG);
        fire("w_grn2", 4'd6, MG);
        fire("w_myel", 4'd2, MY);
        walk_btn = 1'b1;
        fire("w_walk", 4'd3, WK);
        tick();
        walk_btn = 1'b0;
        chk("w_walk_hold", 4'd3, 1'b0, WK);
        fire("w_sgrn", 4'd6, SG);
        fire("w_syel", 4'd2, SY);
        fire("w_mgrn", 4'd6, MG);
        fire("w_grn2b", 4'd6, MG);
        fire("w_myelb", 4'd2, MY);
        fire("w_nowalk", 4'd6, SG);

        // Program base=0 (stored as 1) during SIDE_GRN
        prog_sync = 1'b1; time_sel = 2'b00; time_value = 4'd0;
        tick();
        prog_sync = 1'b0;
        chk("prog_base", 4'd1, 1'b1, MG);
        tick();
        chk("prog_idle", 4'd1, 1'b0, MG);

        // Programming wins over a coincident expiry event
        sensor = 1'b1;
        expired = 1'b1; prog_sync = 1'b1; time_sel = 2'b10; time_value = 4'd5;
        tick();
        expired = 1'b0; prog_sync = 1'b0;
        chk("prog_vs_exp", 4'd1, 1'b1, MG);
        tick(); tick();
        fire("p_grn2", 4'd3, MG);
        fire("p_myel", 4'd5, MY);

        // time_sel=11 is ignored
        prog_sync = 1'b1; time_sel = 2'b11; time_value = 4'd9;
        tick();
        prog_sync = 1'b0;
        chk("prog_sel3", 4'd5, 1'b0, MY);
        fire("p_sgrn", 4'd3, SG);

        // Expired held high gives a single advance
        expired = 1'b1;
        tick();
        chk("held_first", 4'd5, 1'b1, SY);
        for (int i = 0; i < 9; i++) tick();
        chk("held_end", 4'd5, 1'b0, SY);
        expired = 1'b0;
        tick();

        // Rising expiry in a start_timer cycle is ignored
        prog_sync = 1'b1; time_sel = 2'b00; time_value = 4'd6;
        tick();
        prog_sync = 1'b0;
        chk("mask_entry", 4'd6, 1'b1, MG);
        expired = 1'b1;
        tick();
        tick();
        expired = 1'b0;
        chk("mask_ignored", 4'd6, 1'b0, MG);
        tick();
        fire("mask_next", 4'd3, MG);

        // Reset mid-phase restores defaults
        Reset = 1'b1;
        tick();
        chk("rst_mid", 4'd6, 1'b0, MG);
        Reset = 1'b0; sensor = 1'b0;
        tick();
        chk("rst_boot", 4'd6, 1'b1, MG);
        tick();
        fire("rst_grn2", 4'd6, MG);
        fire("rst_myel", 4'd2, MY);

`ifdef NIGHT_FLASH_EN
        night = 1'b1;
        fire("fl_on", 4'd1, MY);
        fire("fl_off", 4'd1, 7'b000_000_0);
        fire("fl_on2", 4'd1, MY);
        night = 1'b0;
        fire("fl_exit", 4'd6, MG);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
